imm_gen_pipe: RTL
=================

Name: imm_gen_pipe

Overview:
- Pipelined, parametrised immediate generator for the decode stage.
- Covers all RV32I/RV64I immediate formats plus CSR zimm, and flags malformed shift encodings.
- Registered output behind a 2-entry skid buffer with valid/ready handshakes on both sides, so decode can stall without recomputing.
- Sits between the instruction register and the register-read / ALU operand mux.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- TAG_W, 5, width of the sideband tag (e.g. rd index or ROB slot) carried alongside each immediate.
- SHAMT_W, derived, equals 5 when XLEN=32 and 6 when XLEN=64; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all buffered entries.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- instr  input  25  instruction bits [31:7].
- immsrc  input  3  format select.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts the head entry.
- immext  output  XLEN  extended immediate.
- out_tag  output  TAG_W  tag of the head entry.
- out_err  output  1  head entry had an illegal encoding.

Behaviour:
- Format decode is combinational on the input side; the result is written into the buffer on an accepted transfer.
- immsrc encoding; sign extension replicates instr[31] up to XLEN:
  - 000 I: instr[31:20], sign-extended.
  - 001 S: {instr[31:25], instr[11:7]}, sign-extended.
  - 010 B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}, sign-extended.
  - 011 SHAMT: instr[20+SHAMT_W-1:20], zero-extended.
    - XLEN=32: err unless instr[31:25] is 0000000 or 0100000.
    - XLEN=64: err unless instr[31:26] is 000000 or 010000.
  - 100 U: {instr[31:12], 12'b0}. Sign-extended from bit 31 when XLEN=64.
  - 101 J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}, sign-extended.
  - 110 ZIMM: instr[19:15], zero-extended.
  - 111: reserved; immext=0, err=1.
  - Any err case stores immext=0.
- Buffer: 2 entries, FIFO order, occupancy count 0..2.
  - in_ready = (count != 2). Registered state only; there is no combinational path from out_ready to in_ready.
  - out_valid = (count != 0). immext, out_tag and out_err always reflect the head entry. They hold stable while out_valid && !out_ready.
- Latency: an accepted request into an empty buffer appears on out_valid on the next rising edge (1 cycle).
- Push and pop in the same cycle: count is unchanged and order is preserved. At count=1 the new entry becomes head on the next edge.
- At count=2, out_ready=1 frees a slot; in_ready rises on the following cycle.
- flush=1: count becomes 0 on the next edge. flush takes priority over a simultaneous push, which is dropped. in_ready remains 1 during flush when count<2.
- Reset (asynchronous, reset_n low, including mid-operation):
  - count=0, out_valid=0, immext=0, out_tag=0, out_err=0.
  - in_ready=1 immediately.
  - Entries in flight are discarded.
- Payload is don't-care when the corresponding valid is low. The implementation must not produce X on the outputs after reset.

Test Plan:
- XLEN=32, back-to-back pushes with out_ready=1, one per cycle in order:
  - I 0xFFF00093 → 0xFFFFFFFF
  - S 0xFE20AE23 → 0xFFFFFFFC
  - U 0x123450B7 → 0x12345000
  - J 0x001000EF → 0x00000800
  - Required: out_err=0 on each; each result appears one cycle after its accept; tags returned in order.
- Shift checks, immsrc=011:
  - 0x4050D093 → immext=5, err=0.
  - 0x0250D093 → immext=0, err=1.
  - immsrc=111 with any instr → immext=0, err=1.
- Backpressure: out_ready=0, push tags 1, 2, 3.
  - in_ready drops after the 2nd accept; tag 3 is held off.
  - Set out_ready=1: outputs tag1 then tag2, then tag3 is accepted; no loss or duplication.
  - Head outputs stay stable while stalled.
- Flush at count=2 with a simultaneous in_valid: next cycle out_valid=0 and the pushed entry is not present.
- XLEN=64:
  - I 0xFFF00093 → 0xFFFFFFFFFFFFFFFF.
  - SHAMT instr[31:20]=0x021 → immext=33, err=0.
  - U 0x800000B7 → 0xFFFFFFFF80000000.
- Assert reset_n low mid-stream with count=2: outputs go to 0 asynchronously and in_ready=1. After release, the first push appears with 1-cycle latency.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator with a 2-entry skid buffer.
// Each accepted request is decoded once and held until the consumer takes it.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      instr,
  input  logic [2:0]       immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  immext,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             err;
  } ent_t;

  // Re-index so bit numbers match the instruction word.
  logic [31:7] ir;
  assign ir = instr;

  logic [XLEN-1:0] imm_c;
  logic            err_c;

  always_comb begin
    imm_c = '0;
    err_c = 1'b0;
    unique case (immsrc)
      3'b000: imm_c = XLEN'($signed(ir[31:20]));
      3'b001: imm_c = XLEN'($signed({ir[31:25], ir[11:7]}));
      3'b010: imm_c = XLEN'($signed({ir[31], ir[7],
                                     ir[30:25], ir[11:8],
                                     1'b0}));
      3'b011: begin
        if (XLEN == 64)
          err_c = !((ir[31:26] == 6'b000000) ||
                    (ir[31:26] == 6'b010000));
        else
          err_c = !((ir[31:25] == 7'b0000000) ||
                    (ir[31:25] == 7'b0100000));
        imm_c = XLEN'(ir[20+SHAMT_W-1:20]);
      end
      3'b100: imm_c = XLEN'($signed({ir[31:12], 12'b0}));
      3'b101: imm_c = XLEN'($signed({ir[31], ir[19:12],
                                     ir[20], ir[30:21],
                                     1'b0}));
      3'b110: imm_c = XLEN'(ir[19:15]);
      3'b111: err_c = 1'b1;
    endcase
    if (err_c) imm_c = '0;
  end

  ent_t       new_e;
  ent_t       head_q, head_d;
  ent_t       tail_q, tail_d;
  logic [1:0] cnt_q, cnt_d;
  logic       push, pop;

  assign new_e = '{imm: imm_c, tag: in_tag, err: err_c};

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign immext    = head_q.imm;
  assign out_tag   = head_q.tag;
  assign out_err   = head_q.err;

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      unique case (cnt_q)
        2'd0: begin
          if (push) begin
            head_d = new_e;
            cnt_d  = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_d = new_e;
          end else if (push) begin
            tail_d = new_e;
            cnt_d  = 2'd2;
          end else if (pop) begin
            cnt_d  = 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head_d = tail_q;
            cnt_d  = 2'd1;
          end
        end
        default: cnt_d = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule
